// File: rtl/spi_config_regs.sv
// spi_config_regs
// Write-only serial configuration slave. Bits arrive on serial_in and are
// sampled on the rising edge of sclk. The first byte of a frame is a register
// address; every following byte is written to the current address, and the
// address then auto-increments. A frame only ends on reset.
//
// Ports:
//   sclk                  in   1  serial clock, the only clock
//   rstn                  in   1  synchronous active-low reset
//   serial_in             in   1  serial data
//   load_cnt_ser          out  8  bits received since reset, saturates at 255
//   select_reg            out  3  low 3 bits of the current register address
//   trigger_channel_mask  out  8  register at ADDR_TRIG
//   instruction           out  8  register at ADDR_INSTR
//   mode                  out  8  register at ADDR_MODE
//
// Build option:
//   SPI_MSB_FIRST_EN  when defined, bytes are shifted in MSB first;
//                     the default is LSB first.
module spi_config_regs #(
  parameter logic [7:0] ADDR_TRIG  = 8'd1,
  parameter logic [7:0] ADDR_INSTR = 8'd2,
  parameter logic [7:0] ADDR_MODE  = 8'd3,
  parameter logic [7:0] MODE_RST   = 8'h00
) (
  input  logic       sclk,
  input  logic       rstn,
  input  logic       serial_in,
  output logic [7:0] load_cnt_ser,
  output logic [2:0] select_reg,
  output logic [7:0] trigger_channel_mask,
  output logic [7:0] instruction,
  output logic [7:0] mode
);

  typedef enum logic {
    ST_ADDR = 1'b0,
    ST_DATA = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_shift;
  logic [2:0] r_bit_idx;
  logic [7:0] r_addr;
  logic [7:0] r_cnt;
  logic [7:0] r_trig;
  logic [7:0] r_instr;
  logic [7:0] r_mode;

  logic [7:0] w_shift_nxt;
  logic       w_byte_done;
  logic [7:0] w_addr_nxt;
  logic       w_wr_trig;
  logic       w_wr_instr;
  logic       w_wr_mode;

  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? 8'hFF : val + 8'd1;
  endfunction

  // The shift value after this edge is also the completed byte when the
  // bit index wraps, so one expression serves both purposes.
`ifdef SPI_MSB_FIRST_EN
  assign w_shift_nxt = {r_shift[6:0], serial_in};
`else
  assign w_shift_nxt = {serial_in, r_shift[7:1]};
`endif

  assign w_byte_done = (r_bit_idx == 3'd7);

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_wr_trig   = 1'b0;
    w_wr_instr  = 1'b0;
    w_wr_mode   = 1'b0;
    if (w_byte_done) begin
      case (r_state)
        ST_ADDR: begin
          w_addr_nxt  = w_shift_nxt;
          w_state_nxt = ST_DATA;
        end
        ST_DATA: begin
          // Unmapped addresses fall through with no write; the address
          // still advances so bursts stay aligned with the register map.
          w_wr_trig  = (r_addr == ADDR_TRIG);
          w_wr_instr = (r_addr == ADDR_INSTR);
          w_wr_mode  = (r_addr == ADDR_MODE);
          w_addr_nxt = r_addr + 8'd1;
        end
        default: w_state_nxt = ST_ADDR;
      endcase
    end
  end

  always_ff @(posedge sclk) begin
    if (!rstn) begin
      r_state   <= ST_ADDR;
      r_shift   <= 8'h00;
      r_bit_idx <= 3'd0;
      r_addr    <= 8'h00;
      r_cnt     <= 8'h00;
      r_trig    <= 8'h00;
      r_instr   <= 8'h00;
      r_mode    <= MODE_RST;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_idx <= r_bit_idx + 3'd1;
      r_addr    <= w_addr_nxt;
      r_cnt     <= sat_inc8(r_cnt);
      if (w_wr_trig)  r_trig  <= w_shift_nxt;
      if (w_wr_instr) r_instr <= w_shift_nxt;
      if (w_wr_mode)  r_mode  <= w_shift_nxt;
    end
  end

  // select_reg always mirrors the address register, so it moves on the same
  // edge as the address byte or the post-write increment.
  assign select_reg           = r_addr[2:0];
  assign load_cnt_ser         = r_cnt;
  assign trigger_channel_mask = r_trig;
  assign instruction          = r_instr;
  assign mode                 = r_mode;

endmodule

// File: tb/tb_spi_config_regs.sv
module tb_spi_config_regs;

  localparam logic [7:0] MODE_RST = 8'h00;

  logic       sclk = 1'b0;
  logic       rstn = 1'b0;
  logic       serial_in = 1'b0;
  logic [7:0] load_cnt_ser;
  logic [2:0] select_reg;
  logic [7:0] trigger_channel_mask;
  logic [7:0] instruction;
  logic [7:0] mode;

  spi_config_regs #(
    .ADDR_TRIG (8'd1),
    .ADDR_INSTR(8'd2),
    .ADDR_MODE (8'd3),
    .MODE_RST  (MODE_RST)
  ) dut (
    .sclk                (sclk),
    .rstn                (rstn),
    .serial_in           (serial_in),
    .load_cnt_ser        (load_cnt_ser),
    .select_reg          (select_reg),
    .trigger_channel_mask(trigger_channel_mask),
    .instruction         (instruction),
    .mode                (mode)
  );

  always #5 sclk = ~sclk;

  typedef struct packed {
    logic [7:0] cnt;
    logic [2:0] sel;
    logic [7:0] trig;
    logic [7:0] instr;
    logic [7:0] mode;
  } snap_t;

  snap_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model of the register map, advanced as stimulus is driven
  logic       m_data;
  logic [7:0] m_addr;
  logic [7:0] m_cnt;
  logic [7:0] m_trig;
  logic [7:0] m_instr;
  logic [7:0] m_mode;

  function automatic void model_reset();
    m_data  = 1'b0;
    m_addr  = 8'h00;
    m_cnt   = 8'h00;
    m_trig  = 8'h00;
    m_instr = 8'h00;
    m_mode  = MODE_RST;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    m_cnt = (int'(m_cnt) + 8 > 255) ? 8'd255 : m_cnt + 8'd8;
    if (!m_data) begin
      m_addr = b;
      m_data = 1'b1;
    end else begin
      if (m_addr == 8'd1) m_trig  = b;
      if (m_addr == 8'd2) m_instr = b;
      if (m_addr == 8'd3) m_mode  = b;
      m_addr = m_addr + 8'd1;
    end
    q.push_back({m_cnt, m_addr[2:0], m_trig, m_instr, m_mode});
  endfunction

  function automatic snap_t dut_snap();
    return {load_cnt_ser, select_reg, trigger_channel_mask, instruction, mode};
  endfunction

  // Data changes on the falling edge; outputs are read 1 time unit after
  // the rising edge that samples the bit.
  task automatic send_bit(input logic b);
    @(negedge sclk);
    rstn      = 1'b1;
    serial_in = b;
    @(posedge sclk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    for (int i = 0; i < 8; i++) begin
`ifdef SPI_MSB_FIRST_EN
      send_bit(b[7-i]);
`else
      send_bit(b[i]);
`endif
    end
  endtask

  // Leaves rstn low after one rising edge; the next send_bit releases it.
  // serial_in is high so a bit that wrongly wins over reset would show.
  task automatic do_reset();
    @(negedge sclk);
    rstn      = 1'b0;
    serial_in = 1'b1;
    @(posedge sclk);
    #1;
    model_reset();
    q.delete();
  endtask

  task automatic test_reset();
    snap_t got, exp;
    do_reset();
    got = dut_snap();
    exp = {8'd0, 3'd0, 8'h00, 8'h00, MODE_RST};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL reset got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_single_write();
    logic [7:0] bytes[2] = '{8'h01, 8'hA5};
    snap_t got, exp;
    do_reset();
    foreach (bytes[i]) begin
      send_byte(bytes[i]);
      exp = q.pop_front();
      got = dut_snap();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL single_write byte%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_burst();
    logic [7:0] bytes[4] = '{8'h01, 8'h11, 8'h22, 8'h33};
    snap_t got, exp;
    do_reset();
    foreach (bytes[i]) begin
      send_byte(bytes[i]);
      exp = q.pop_front();
      got = dut_snap();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL burst byte%0d got=%h exp=%h", i, got, exp);
      end
    end
    // Fixed end state of the burst, independent of the model
    exp = {8'd32, 3'd4, 8'h11, 8'h22, 8'h33};
    got = dut_snap();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL burst_final got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_invalid_addr();
    logic [7:0] bytes[3] = '{8'hAA, 8'hFF, 8'h00};
    snap_t got, exp;
    do_reset();
    foreach (bytes[i]) begin
      send_byte(bytes[i]);
      exp = q.pop_front();
      got = dut_snap();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL invalid_addr byte%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] bytes[2] = '{8'h03, 8'h5A};
    snap_t got, exp;
    do_reset();
    send_byte(8'h03);
    exp = q.pop_front();
    got = dut_snap();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL midrst_addr got=%h exp=%h", got, exp);
    end
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    do_reset();
    got = dut_snap();
    exp = {8'd0, 3'd0, 8'h00, 8'h00, MODE_RST};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL midrst_cleared got=%h exp=%h", got, exp);
    end
    // 0x03 must be taken as an address again, then 0x5A lands in mode
    foreach (bytes[i]) begin
      send_byte(bytes[i]);
      exp = q.pop_front();
      got = dut_snap();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL midrst_frame byte%0d got=%h exp=%h", i, got, exp);
      end
    end
    total++;
    if (mode !== 8'h5A) begin
      bad++;
      $display("FAIL midrst_mode got=%h exp=5a", mode);
    end
  endtask

  // 38 bytes = 304 bits. Start address 0xDF makes data bytes 35..37 land on
  // addresses 1..3, all after the counter has saturated; byte 37 starts at
  // bit 296.
  task automatic test_saturation();
    snap_t      got, exp;
    logic [7:0] b;
    do_reset();
    for (int j = 0; j < 38; j++) begin
      b = (j == 0) ? 8'hDF : 8'(j * 37 + 5);
      send_byte(b);
      exp = q.pop_front();
      got = dut_snap();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL saturation byte%0d got=%h exp=%h", j, got, exp);
      end
    end
    exp = {8'd255, 3'd4, 8'(35 * 37 + 5), 8'(36 * 37 + 5), 8'(37 * 37 + 5)};
    got = dut_snap();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL saturation_final got=%h exp=%h", got, exp);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_write();
    test_burst();
    test_invalid_addr();
    test_reset_mid_byte();
    test_saturation();
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
